// File: rtl/dmem_port_arbiter.sv
// Purpose: arbitrates the single data-memory port between the core memory stage and a DMA/debug requester,
//          with one outstanding transaction, load data returned to the owner, and a timeout on every access.
// Latency: grant at N (combinational), mem_req_o at N+1, owner rvalid at N+3 at best (3 cycles back-to-back).
// Backpressure: requesters hold req and payload until their gnt pulse. The core is stalled while its access is pending.
// Ports: clk_i/rst_ni (async active-low); core_*/dma_* requester side (req/we/addr/wdata/funct3 in; gnt/rvalid/rdata out);
//        core_stall_o; mem_* cache side (req/we/addr/wdata/funct3 out; gnt/rvalid/rdata in); timeout_o (sticky).
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_WAIT     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  input  logic [2:0]            core_funct3_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  core_stall_o,
  input  logic                  dma_req_i,
  input  logic                  dma_we_i,
  input  logic [ADDR_WIDTH-1:0] dma_addr_i,
  input  logic [DATA_WIDTH-1:0] dma_wdata_i,
  input  logic [2:0]            dma_funct3_i,
  output logic                  dma_gnt_o,
  output logic                  dma_rvalid_o,
  output logic [DATA_WIDTH-1:0] dma_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [2:0]            mem_funct3_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  timeout_o
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_e;
  typedef enum logic {OWN_CORE, OWN_DMA} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q;
  logic [WCW-1:0]  wait_q;
  logic [SCW-1:0]  starve_q;
  logic            core_gnt, dma_gnt;
  logic            complete, timed_out, wait_hit;
  logic [DATA_WIDTH-1:0] rsp_data;

  // The counter is cleared at capture and advanced once per REQ/RSP cycle; the
  // increment that would bring it to MAX_WAIT is the timeout cycle, so the
  // forced completion lands MAX_WAIT cycles after the grant.
  assign wait_hit = (wait_q == WCW'(MAX_WAIT - 1));

  always_comb begin
    state_d   = state_q;
    core_gnt  = 1'b0;
    dma_gnt   = 1'b0;
    complete  = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Grants are gated by reset so nothing is promised while the block is held.
        if (rst_ni) begin
          if (dma_req_i && (!core_req_i || starve_q == SCW'(STARVE_LIMIT))) begin
            dma_gnt = 1'b1;
            state_d = S_REQ;
          end else if (core_req_i) begin
            core_gnt = 1'b1;
            state_d  = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A response while still requesting is meaningless and ignored.
        if (wait_hit) begin
          timed_out = 1'b1;
          complete  = 1'b1;
          state_d   = S_IDLE;
        end else if (mem_gnt_i) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        // A real response on the timeout cycle wins over the timeout.
        if (mem_rvalid_i) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else if (wait_hit) begin
          timed_out = 1'b1;
          complete  = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stores and timed-out accesses return zero data.
  assign rsp_data = (timed_out || mem_we_o) ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_CORE;
      wait_q        <= '0;
      starve_q      <= '0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_funct3_o  <= '0;
      core_rvalid_o <= 1'b0;
      dma_rvalid_o  <= 1'b0;
      core_rdata_o  <= '0;
      dma_rdata_o   <= '0;
      timeout_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_rvalid_o <= 1'b0;
      dma_rvalid_o  <= 1'b0;

      if (core_gnt) begin
        owner_q      <= OWN_CORE;
        wait_q       <= '0;
        mem_we_o     <= core_we_i;
        mem_addr_o   <= core_addr_i;
        mem_wdata_o  <= core_wdata_i;
        mem_funct3_o <= core_funct3_i;
      end else if (dma_gnt) begin
        owner_q      <= OWN_DMA;
        wait_q       <= '0;
        mem_we_o     <= dma_we_i;
        mem_addr_o   <= dma_addr_i;
        mem_wdata_o  <= dma_wdata_i;
        mem_funct3_o <= dma_funct3_i;
      end else if (state_q != S_IDLE) begin
        wait_q <= wait_q + 1'b1;
      end

      // Starvation count: DMA lost a contested round; saturates at the limit.
      if (dma_gnt) begin
        starve_q <= '0;
      end else if (core_gnt && dma_req_i && starve_q != SCW'(STARVE_LIMIT)) begin
        starve_q <= starve_q + 1'b1;
      end

      if (complete) begin
        if (owner_q == OWN_DMA) begin
          dma_rvalid_o <= 1'b1;
          dma_rdata_o  <= rsp_data;
        end else begin
          core_rvalid_o <= 1'b1;
          core_rdata_o  <= rsp_data;
        end
      end

      if (timed_out) begin
        timeout_o <= 1'b1;
      end
    end
  end

  assign core_gnt_o   = core_gnt;
  assign dma_gnt_o    = dma_gnt;
  assign mem_req_o    = (state_q == S_REQ);
  assign core_stall_o = (core_req_i & ~core_gnt) | ((owner_q == OWN_CORE) & (state_q != S_IDLE));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i, core_we_i, dma_req_i, dma_we_i;
  logic [31:0] core_addr_i, core_wdata_i, dma_addr_i, dma_wdata_i;
  logic [2:0]  core_funct3_i, dma_funct3_i;
  logic        core_gnt_o, core_rvalid_o, core_stall_o, dma_gnt_o, dma_rvalid_o;
  logic [31:0] core_rdata_o, dma_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, timeout_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [2:0]  mem_funct3_o;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  dmem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(15), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_funct3_i(core_funct3_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .core_stall_o(core_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_funct3_i(dma_funct3_i),
    .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_funct3_o(mem_funct3_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs are sampled #1 later, far from either edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic        exp_dma;
    logic [31:0] last_core;

    rst_ni = 1'b0;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0; core_funct3_i = 3'd2;
    dma_req_i = 1'b1;  dma_we_i = 1'b0;  dma_addr_i = '0;  dma_wdata_i = '0;  dma_funct3_i = 3'd2;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Reset state, with requests present: no grants while held.
    cyc(); #1;
    check("rst_core_gnt", core_gnt_o, 0);
    check("rst_dma_gnt", dma_gnt_o, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_rvalids", {core_rvalid_o, dma_rvalid_o}, 0);
    check("rst_rdatas", {core_rdata_o, dma_rdata_o}, 0);
    check("rst_timeout", timeout_o, 0);
    core_req_i = 1'b0; dma_req_i = 1'b0;
    #2 rst_ni = 1'b1;

    // Core load, fastest path: gnt N, rvalid N+3.
    cyc(); core_req_i = 1'b1; core_addr_i = 32'h40; #1;
    check("ld_core_gnt", core_gnt_o, 1);
    check("ld_dma_gnt", dma_gnt_o, 0);
    cyc(); core_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    check("ld_mem_req", mem_req_o, 1);
    check("ld_mem_addr", mem_addr_o, 32'h40);
    check("ld_mem_we", mem_we_o, 0);
    check("ld_stall_n1", core_stall_o, 1);
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
    check("ld_mem_req_rsp", mem_req_o, 0);
    check("ld_stall_n2", core_stall_o, 1);
    check("ld_no_early_rvalid", core_rvalid_o, 0);
    cyc(); mem_rvalid_i = 1'b0; #1;
    check("ld_core_rvalid", core_rvalid_o, 1);
    check("ld_core_rdata", core_rdata_o, 32'hDEADBEEF);
    check("ld_dma_rvalid", dma_rvalid_o, 0);
    check("ld_stall_n3", core_stall_o, 0);
    cyc(); #1;
    check("ld_rvalid_pulse", core_rvalid_o, 0);

    // Stray response while idle is dropped.
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD0BAD;
    cyc(); mem_rvalid_i = 1'b0; #1;
    check("stray_idle_rvalid", {core_rvalid_o, dma_rvalid_o}, 0);
    check("stray_idle_mem_req", mem_req_o, 0);
    check("stray_idle_rdata", core_rdata_o, 32'hDEADBEEF);

    // DMA store, cache grant delayed 3 cycles, stray response during REQ.
    cyc(); dma_req_i = 1'b1; dma_we_i = 1'b1; dma_addr_i = 32'h100; dma_wdata_i = 32'h12345678; #1;
    check("st_dma_gnt", dma_gnt_o, 1);
    check("st_stall_idle", core_stall_o, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      dma_req_i = 1'b0; dma_addr_i = 32'hFFFF_FFFF; dma_wdata_i = '0;
      mem_rvalid_i = (k == 2); mem_rdata_i = 32'hAAAA5555;
      mem_gnt_i = (k == 4);
      #1;
      check("st_mem_req_held", mem_req_o, 1);
      check("st_payload", {mem_we_o, mem_addr_o, mem_wdata_o}, {1'b1, 32'h100, 32'h12345678});
      check("st_stall", core_stall_o, 0);
      check("st_no_rvalid", dma_rvalid_o, 0);
    end
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; #1;
    check("st_mem_req_rsp", mem_req_o, 0);
    cyc(); mem_rvalid_i = 1'b0; #1;
    check("st_dma_rvalid", dma_rvalid_o, 1);
    check("st_dma_rdata", dma_rdata_o, 0);
    check("st_core_untouched", {core_rvalid_o, core_rdata_o}, {1'b0, 32'hDEADBEEF});

    // Starvation: both held, expect core x4, DMA, core x4, DMA.
    cyc();
    dma_we_i = 1'b0; dma_addr_i = 32'h200; core_addr_i = 32'h300;
    core_req_i = 1'b1; dma_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    last_core = 32'hDEADBEEF;
    for (int t = 0; t < 10; t++) begin
      exp_dma = (t == 4 || t == 9);
      check("arb_core_gnt", core_gnt_o, !exp_dma);
      check("arb_dma_gnt", dma_gnt_o, exp_dma);
      mem_rdata_i = 32'h1000 + t;
      cyc(); #1;
      check("arb_mem_req", mem_req_o, 1);
      check("arb_stall", core_stall_o, 1);
      cyc(); #1;
      cyc();
      if (t == 9) begin
        core_req_i = 1'b0; dma_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      end
      #1;
      if (exp_dma) begin
        check("arb_dma_rsp", {dma_rvalid_o, core_rvalid_o, dma_rdata_o, core_rdata_o},
              {1'b1, 1'b0, 32'h1000 + t, last_core});
      end else begin
        check("arb_core_rsp", {core_rvalid_o, dma_rvalid_o, core_rdata_o}, {1'b1, 1'b0, 32'h1000 + t});
        last_core = 32'h1000 + t;
      end
    end

    // Timeout: cache accepts but never responds.
    cyc(); core_req_i = 1'b1; core_addr_i = 32'h44; #1;
    check("to_gnt", core_gnt_o, 1);
    cyc(); core_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    cyc(); mem_gnt_i = 1'b0; #1;
    for (int k = 3; k <= 15; k++) begin
      cyc(); #1;
      check("to_waiting", {core_rvalid_o, timeout_o, core_stall_o}, {1'b0, 1'b0, 1'b1});
    end
    cyc(); #1;
    check("to_rvalid_n16", core_rvalid_o, 1);
    check("to_rdata", core_rdata_o, 0);
    check("to_flag", timeout_o, 1);
    check("to_mem_req", mem_req_o, 0);
    cyc(); #1;
    check("to_sticky", {timeout_o, core_rvalid_o}, {1'b1, 1'b0});

    // Next access after timeout is normal.
    core_req_i = 1'b1; core_addr_i = 32'h48; #1;
    check("post_to_gnt", core_gnt_o, 1);
    cyc(); core_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    cyc(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA; #1;
    cyc(); mem_rvalid_i = 1'b0; #1;
    check("post_to_rsp", {core_rvalid_o, core_rdata_o, timeout_o}, {1'b1, 32'h55AA55AA, 1'b1});

    // Reset pulse during RSP, then a late response.
    cyc(); core_req_i = 1'b1; core_addr_i = 32'h80; #1;
    check("rr_gnt", core_gnt_o, 1);
    cyc(); core_req_i = 1'b0; mem_gnt_i = 1'b1; #1;
    cyc(); mem_gnt_i = 1'b0; #1;
    check("rr_in_rsp", {mem_req_o, core_stall_o}, {1'b0, 1'b1});
    #2 rst_ni = 1'b0;
    #1;
    check("rr_mem_out", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_funct3_o}, 0);
    check("rr_rdata", {core_rdata_o, dma_rdata_o}, 0);
    check("rr_flags", {timeout_o, core_rvalid_o, dma_rvalid_o, core_stall_o}, 0);
    #1 rst_ni = 1'b1;
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBADBAD00; #1;
    check("rr_late_idle", {mem_req_o, core_stall_o}, 0);
    cyc(); mem_rvalid_i = 1'b0; #1;
    check("rr_no_rvalid", {core_rvalid_o, dma_rvalid_o}, 0);
    check("rr_rdata_after", {core_rdata_o, dma_rdata_o, timeout_o}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
